// File: rtl/countdown_timer.sv
// countdown_timer
//   Four-digit BCD mm:ss countdown timer. A preset is loaded (each digit
//   clamped to valid BCD), start begins counting, and each 1 Hz tick in RUN
//   decrements the count by one second through a borrow chain. Reaching 00:00
//   pulses done and enters EXPIRED, which only load or reset can leave.
//
//   Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN
//     When defined, the tick at 00:01 reloads the count from the preset
//     register and the timer stays in RUN. done still pulses and expired
//     never asserts.
//
// Ports
//   clk                          in   system clock, rising edge
//   reset                        in   synchronous active-high, clears all state
//   tick                         in   one-cycle 1 Hz enable pulse
//   pause                        in   level, holds the count while in RUN
//   load                         in   pulse, captures clamped preset, aborts run
//   start                        in   pulse, IDLE -> RUN when count is non-zero
//   preset_min_tens/min_ones/
//   preset_sec_tens/sec_ones     in   4-bit BCD preset digits
//   min_tens/min_ones/
//   sec_tens/sec_ones            out  current count digits, registered
//   running                      out  high in RUN (also while paused)
//   expired                      out  high in EXPIRED
//   done                         out  one-cycle pulse when the count completes
module countdown_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       pause,
  input  logic       load,
  input  logic       start,
  input  logic [3:0] preset_min_tens,
  input  logic [3:0] preset_min_ones,
  input  logic [3:0] preset_sec_tens,
  input  logic [3:0] preset_sec_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t      state, state_next;
  // Count and preset are held packed as {min_tens, min_ones, sec_tens, sec_ones}.
  logic [15:0] count, count_next;
  logic [15:0] preset, preset_next;
  logic [15:0] load_val;
  logic        done_next;

  function automatic logic [3:0] clamp_ones(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [3:0] clamp_tens(input logic [3:0] d);
    return (d > 4'd5) ? 4'd5 : d;
  endfunction

  // One-second BCD decrement. Each digit that is already zero wraps to its
  // maximum and borrows from the next more significant digit. Only called
  // with a non-zero count, so min_tens never wraps.
  function automatic logic [15:0] dec_bcd(input logic [15:0] c);
    logic [3:0] mt, mo, st, so;
    mt = c[15:12];
    mo = c[11:8];
    st = c[7:4];
    so = c[3:0];
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign load_val = {clamp_tens(preset_min_tens), clamp_ones(preset_min_ones),
                     clamp_tens(preset_sec_tens), clamp_ones(preset_sec_ones)};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= 16'h0000;
      preset  <= 16'h0000;
      done    <= 1'b0;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      preset  <= preset_next;
      done    <= done_next;
      running <= (state_next == RUN);
      expired <= (state_next == EXPIRED);
    end
  end

  // Priority load > start > tick. start only acts in IDLE, so a start seen
  // in RUN falls through and a simultaneous tick is still honoured.
  always_comb begin
    state_next  = state;
    count_next  = count;
    preset_next = preset;
    done_next   = 1'b0;
    if (load) begin
      preset_next = load_val;
      count_next  = load_val;
      state_next  = IDLE;
    end else if (start && (state == IDLE) && (count != 16'h0000)) begin
      state_next = RUN;
    end else if ((state == RUN) && tick && !pause && (count != 16'h0000)) begin
      done_next = (count == 16'h0001);
      if (count == 16'h0001) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        count_next = preset;
`else
        count_next = 16'h0000;
        state_next = EXPIRED;
`endif
      end else begin
        count_next = dec_bcd(count);
      end
    end
  end

  assign min_tens = count[15:12];
  assign min_ones = count[11:8];
  assign sec_tens = count[7:4];
  assign sec_ones = count[3:0];

endmodule
